// File: rtl/inv_key_schedule_if.sv
// Handshake/key bus for inv_key_schedule; master = key consumer side, slave = schedule block.
interface inv_key_schedule_if;
  logic         iStart;
  logic [127:0] iKey;
  logic         iReady;
  logic [127:0] oRoundKey;
  logic [3:0]   oRound;
  logic         oValid;
  logic         oBusy;
  logic         oDone;

  modport master (
    output iStart, iKey, iReady,
    input  oRoundKey, oRound, oValid, oBusy, oDone
  );

  modport slave (
    input  iStart, iKey, iReady,
    output oRoundKey, oRound, oValid, oBusy, oDone
  );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: emits round keys ROUNDS..0, one inverse expansion step per handshake.
// Optional INVKEY_FWD_PRECOMPUTE_EN: iKey is the cipher key and ROUNDS forward steps run first.
module inv_key_schedule #(
  parameter int unsigned ROUNDS = 10
) (
  input logic              iClk,
  input logic              iRst,
  inv_key_schedule_if.slave bus
);

  if (ROUNDS == 0 || ROUNDS > 10) begin : g_bad_rounds
    $error("inv_key_schedule: ROUNDS must be in 1..10");
  end

`ifdef INVKEY_FWD_PRECOMPUTE_EN
  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (product of a^2..a^128), then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     round_q, round_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef INVKEY_FWD_PRECOMPUTE_EN
  logic [3:0]     cnt_q, cnt_d;
`endif

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] v3;
  logic [31:0] sb_src;
  logic [31:0] sw;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];
  assign v3 = w3 ^ w2;

  // Single S-box word path shared by forward (RotWord(w3)) and inverse (RotWord(w3^w2)) steps.
  assign sb_src = (state_q == EMIT) ? v3 : w3;
  assign sw     = sub_word({sb_src[23:0], sb_src[31:24]});

  always_comb begin
    logic [31:0] n0, n1, n2;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    n0      = '0;
    n1      = '0;
    n2      = '0;
`ifdef INVKEY_FWD_PRECOMPUTE_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          key_d  = bus.iKey;
          busy_d = 1'b1;
`ifdef INVKEY_FWD_PRECOMPUTE_EN
          state_d = FWD;
          cnt_d   = '0;
`else
          state_d = EMIT;
          round_d = ROUNDS[3:0];
          valid_d = 1'b1;
`endif
        end
      end
`ifdef INVKEY_FWD_PRECOMPUTE_EN
      FWD: begin
        n0    = w0 ^ sw ^ {rcon(cnt_q + 4'd1), 24'h000000};
        n1    = w1 ^ n0;
        n2    = w2 ^ n1;
        key_d = {n0, n1, n2, w3 ^ n2};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ROUNDS - 1)) begin
          state_d = EMIT;
          round_d = ROUNDS[3:0];
          valid_d = 1'b1;
        end
      end
`endif
      EMIT: begin
        if (bus.iReady) begin
          if (round_q != 4'd0) begin
            n0      = w0 ^ sw ^ {rcon(round_q), 24'h000000};
            key_d   = {n0, w1 ^ w0, w2 ^ w1, v3};
            round_d = round_q - 4'd1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef INVKEY_FWD_PRECOMPUTE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef INVKEY_FWD_PRECOMPUTE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.oRoundKey = key_q;
  assign bus.oRound    = round_q;
  assign bus.oValid    = valid_q;
  assign bus.oBusy     = busy_q;
  assign bus.oDone     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Randomized self-checking bench for inv_key_schedule against a FIPS-197 style key-expansion model.
module tb_inv_key_schedule;
  localparam int unsigned ROUNDS = 10;
`ifdef INVKEY_FWD_PRECOMPUTE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_ZERO = 128'h0;
  localparam int M_READY = 0, M_STALL = 1, M_RANDOM = 2, M_START4 = 3, M_RESET5 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  inv_key_schedule_if bus();

  inv_key_schedule #(.ROUNDS(ROUNDS)) dut (.iClk(clk), .iRst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from log/antilog tables over generator 3, affine applied bit by bit.
  task automatic build_sbox();
    logic [7:0] alog [256];
    int lg [256];
    logic [7:0] p, inv, s, c;
    p = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 255; i++) begin
      alog[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
      for (int j = 0; j < 8; j++)
        s[j] = inv[j] ^ inv[(j+4)%8] ^ inv[(j+5)%8] ^ inv[(j+6)%8] ^ inv[(j+7)%8] ^ c[j];
      sbox[x] = s;
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] k0, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4*r + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Reference model state (transaction level: expected round, pending precompute cycles).
  logic [127:0] cur_cipher = '0;
  logic [127:0] m_keys [0:10];
  logic [127:0] cap [0:10];
  logic [127:0] m_last_key = '0;
  bit m_active = 0, m_done = 0;
  int m_wait = 0, m_round = 0, m_last_round = 0, hs_count = 0;

  always @(negedge clk) begin
    bit exp_valid;
    if (rst) begin
      chk("rst_valid", bus.oValid, 0);
      chk("rst_busy", bus.oBusy, 0);
      chk("rst_round", bus.oRound, 0);
      chk("rst_key", bus.oRoundKey, 0);
      m_active = 0; m_wait = 0; m_round = 0; m_done = 0;
      m_last_key = '0; m_last_round = 0;
    end else begin
      exp_valid = m_active && (m_wait == 0);
      chk("valid", bus.oValid, exp_valid);
      chk("busy", bus.oBusy, m_active);
      chk("done", bus.oDone, m_done);
      if (exp_valid) begin
        chk("round", bus.oRound, m_round);
        chk("key", bus.oRoundKey, m_keys[m_round]);
      end else if (!m_active) begin
        chk("idle_round", bus.oRound, m_last_round);
        chk("idle_key", bus.oRoundKey, m_last_key);
      end
      m_done = 0;
      if (!m_active) begin
        if (bus.iStart) begin
          m_active = 1;
          m_wait = PRE ? ROUNDS : 0;
          m_round = ROUNDS;
          for (int r = 0; r <= ROUNDS; r++) m_keys[r] = round_key(cur_cipher, r);
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (bus.iReady) begin
        hs_count++;
        cap[m_round] = bus.oRoundKey;
        if (m_round > 0) m_round--;
        else begin
          m_active = 0; m_done = 1;
          m_last_key = m_keys[0]; m_last_round = 0;
        end
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 of the cycle where oDone is seen (or reset fires).
  task automatic run(input logic [127:0] k0, input int mode);
    int cyc, first, stall;
    bit done, aborted;
    cyc = 0; first = -1; stall = 0; done = 0; aborted = 0;
    cur_cipher = k0;
    bus.iKey   = PRE ? k0 : round_key(k0, ROUNDS);
    bus.iStart = 1'b1;
    bus.iReady = 1'b1;
    hs_count   = 0;
    while (!done && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
      bus.iStart = 1'b0;
      bus.iReady = 1'b1;
      if (bus.oValid && first < 0) first = cyc;
      if (bus.oDone) done = 1;
      else begin
        case (mode)
          M_STALL:
            if (bus.oValid && bus.oRound == 4'd7 && stall < 5) begin
              bus.iReady = 1'b0;
              stall++;
            end
          M_RANDOM: begin
            bus.iReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
              bus.iStart = 1'b1;
              bus.iKey = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
          end
          M_START4:
            if (bus.oValid && bus.oRound == 4'd4) begin
              bus.iStart = 1'b1;
              bus.iKey = ~bus.iKey;
            end
          M_RESET5:
            if (bus.oValid && bus.oRound == 4'd5) begin
              rst = 1'b1;
              #1;
              chk("async_rst_valid", bus.oValid, 0);
              chk("async_rst_round", bus.oRound, 0);
              chk("async_rst_key", bus.oRoundKey, 0);
              chk("async_rst_busy", bus.oBusy, 0);
              aborted = 1; done = 1;
            end
          default: ;
        endcase
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout actual=no_done required=done_within_300_cycles");
    end
    chk("first_valid_latency", first, PRE ? ROUNDS + 1 : 1);
    if (!aborted) chk("handshakes", hs_count, ROUNDS + 1);
  endtask

  initial begin
    build_sbox();
    bus.iStart = 1'b0;
    bus.iKey   = '0;
    bus.iReady = 1'b0;
    chk("model_fips_r10", round_key(K_FIPS, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_fips_r9", round_key(K_FIPS, 9), 128'hac7766f319fadc2128d12941575c006e);
    chk("model_zero_r10", round_key(K_ZERO, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("model_zero_r1", round_key(K_ZERO, 1), 128'h62636363626363636263636362636363);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    run(K_FIPS, M_READY);
    if (PRE) chk("lit_fips_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("lit_fips_r9", cap[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("lit_fips_r0", cap[0], K_FIPS);

    run(K_FIPS, M_STALL);
    chk("stall_r7", cap[7], round_key(K_FIPS, 7));

    run(K_ZERO, M_READY);
    if (PRE) chk("lit_zero_r10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("lit_zero_r1", cap[1], 128'h62636363626363636263636362636363);
    chk("lit_zero_r0", cap[0], 128'h0);

    run(K_FIPS, M_START4);
    // Starts in the oDone cycle of the previous schedule.
    run({$urandom(), $urandom(), $urandom(), $urandom()}, M_READY);

    run({$urandom(), $urandom(), $urandom(), $urandom()}, M_RESET5);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;
    run(K_FIPS, M_READY);
    chk("post_reset_r0", cap[0], K_FIPS);

    for (int n = 0; n < 6; n++)
      run({$urandom(), $urandom(), $urandom(), $urandom()}, M_RANDOM);

    bus.iStart = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Sequential AES-128 inverse key schedule for the decryption datapath.
- Takes a 128-bit key and emits round keys in reverse order (round ROUNDS down to round 0), one per valid/ready handshake.
- Each key is derived on the fly by inverting one key-expansion step per cycle; no 1408-bit key store.
- Sits between key load and the iterative InvCipher round engine.

Parameters:
- ROUNDS, 10, number of rounds. Legal range 1..10; any other value is an elaboration error. 10 gives AES-128.

Ports:
- iClk  input  1  clock.
- iRst  input  1  asynchronous, active-high reset.
- iStart  input  1  load iKey and begin a schedule. Honoured only in IDLE.
- iKey  input  128  key word {W0,W1,W2,W3}, MSB first. Meaning depends on INVKEY_FWD_PRECOMPUTE_EN.
- iReady  input  1  consumer accepts oRoundKey this cycle.
- oRoundKey  output  128  current round key {W4r..W4r+3}.
- oRound  output  4  round index r of oRoundKey.
- oValid  output  1  oRoundKey/oRound are valid.
- oBusy  output  1  high in any state other than IDLE.
- oDone  output  1  one-cycle pulse after the round-0 handshake.

Behaviour:
- Reset (async): state=IDLE; oRoundKey=0, oRound=0, oValid=0, oBusy=0, oDone=0. Reset mid-operation aborts immediately with these values.
- States: IDLE, FWD (macro builds only), EMIT.
- IDLE + iStart:
  - Key register <= iKey.
  - Without macro: next state is EMIT with oRound=ROUNDS.
  - With macro: next state is FWD with counter=0.
- FWD, one standard expansion step per cycle:
  - w0' = w0^SubWord(RotWord(w3))^Rcon(c+1); w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - c increments each cycle. After ROUNDS steps, go to EMIT with oRound=ROUNDS.
- EMIT: oValid=1, oRoundKey=key register, oRound=r.
  - iReady=0: all outputs held stable.
  - iReady=1 and r>0: inverse step.
    - v3=w3^w2; v2=w2^w1; v1=w1^w0.
    - v0=w0^SubWord(RotWord(v3))^Rcon(r).
    - r <= r-1. oValid stays high, so a new key is presented next cycle.
  - iReady=1 and r==0: go to IDLE, oValid<=0, oDone<=1 for one cycle.
- Rcon(r) = 01,02,04,08,10,20,40,80,1B,36 in the top byte for r=1..10.
- One SubBytes instance. Its top 32 bits carry RotWord(w3) in FWD and RotWord(w3^w2) in EMIT. Remaining 96 input bits are tied to zero.
- Throughput: one key per cycle under continuous iReady.
- Latency:
  - Without macro: 1 cycle from iStart to first oValid.
  - With macro: ROUNDS+1 cycles.
- iStart while oBusy=1 is ignored, including the final-handshake cycle. iStart in the cycle oDone=1 is accepted.
- In IDLE, oRoundKey and oRound hold their last values and oValid=0.
- All next-state logic is combinational from registered state. All outputs are registered.

Optional Feature:
- Macro INVKEY_FWD_PRECOMPUTE_EN.
- Defined: iKey is the cipher key (round 0). The FWD state runs ROUNDS forward steps before emission, so the block is self-contained for decryption.
- Undefined: iKey must already be the round-ROUNDS key, supplied by the encryption path. The FWD state and its counter are not built, and iStart goes straight to EMIT.

Test Plan:
- Reset check: assert iRst mid-EMIT at r=5 -> oValid=0, oRound=0, oRoundKey=0, oBusy=0 asynchronously. A following iStart runs a complete schedule.
- No macro, iKey=d014f9a8c9ee2589e13f0cc8b6630ca6, iReady=1:
  - r=10 is presented 1 cycle after iStart.
  - r=9 = ac7766f319fadc2128d12941575c006e.
  - r=0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Exactly 11 handshakes, then a single oDone pulse.
- Backpressure: same key, drop iReady for 5 cycles while r=7 -> oRoundKey and oRound stable for those 5 cycles, and no key is skipped or duplicated afterwards.
- Macro defined, iKey=2b7e151628aed2a6abf7158809cf4f3c:
  - First oValid 11 cycles after iStart, with r=10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - oBusy=1 from the cycle after iStart through the last handshake.
- All-zero cipher key (macro build) -> r=10 = b4ef5bcb3e92e21123e951cf6f8f188e; r=1 = 62636363626363636263636362636363; r=0 = all zeros.
- iStart pulsed at r=4 -> ignored, sequence continues to r=0. iStart in the oDone cycle -> accepted, and the new schedule begins.
